// File: rtl/kyber_sample_scheduler.sv
// Sequences the shared SHAKE/sampling core through the 16 polys of one Kyber768 encryption.
// Optional feature macro: KYBER_MATRIX_TRANSPOSE_EN (matrix jobs request A^T instead of A).
//
// state  | meaning
// S_IDLE | no run in progress, waiting for start
// S_ISSUE| request for current job held on req_* until accepted
// S_WAIT | sampler working on current job, timeout counter running
// S_DONE | all polys written, done held until start/abort
// S_ERR  | sampler missed its deadline, err_timeout held until start/abort
module kyber_sample_scheduler #(
    parameter int K       = 3,
    parameter int TIMEOUT = 4096,
    parameter int NJOBS   = K * K + 2 * K + 1,
    parameter int JW      = $clog2(NJOBS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    output logic          req_valid,
    input  logic          req_ready,
    output logic          req_is_noise,
    output logic [7:0]    req_x,
    output logic [7:0]    req_y,
    input  logic          rsp_valid,
    output logic          buf_wr_en,
    output logic [JW-1:0] buf_wr_addr,
    output logic          busy,
    output logic          done,
    output logic          err_timeout,
    output logic [JW-1:0] job_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state, state_nxt;
    logic [JW-1:0] job, job_nxt;
    logic [15:0]   tmo_cnt, tmo_cnt_nxt;

    int            job_int;
    int            mat_i;
    int            mat_j;
    int            nonce;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            job     <= '0;
            tmo_cnt <= '0;
        end else begin
            state   <= state_nxt;
            job     <= job_nxt;
            tmo_cnt <= tmo_cnt_nxt;
        end
    end

    always_comb begin
        job_int = int'(job);
        mat_i   = job_int / K;
        mat_j   = job_int % K;
        nonce   = job_int - K * K;
    end

    always_comb begin
        state_nxt    = state;
        job_nxt      = job;
        tmo_cnt_nxt  = tmo_cnt;
        req_valid    = 1'b0;
        req_is_noise = 1'b0;
        req_x        = '0;
        req_y        = '0;
        buf_wr_en    = 1'b0;
        buf_wr_addr  = '0;
        busy         = 1'b0;
        done         = 1'b0;
        err_timeout  = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt   = S_ISSUE;
                    job_nxt     = '0;
                    tmo_cnt_nxt = '0;
                end
            end
            S_ISSUE: begin
                busy      = 1'b1;
                req_valid = 1'b1;
                if (job_int >= K * K) begin
                    req_is_noise = 1'b1;
                    req_x        = 8'(nonce);
                    req_y        = '0;
                end else begin
`ifdef KYBER_MATRIX_TRANSPOSE_EN
                    req_x = 8'(mat_i);
                    req_y = 8'(mat_j);
`else
                    req_x = 8'(mat_j);
                    req_y = 8'(mat_i);
`endif
                end
                if (req_ready) begin
                    state_nxt   = S_WAIT;
                    tmo_cnt_nxt = '0;
                end
            end
            S_WAIT: begin
                busy        = 1'b1;
                tmo_cnt_nxt = tmo_cnt + 16'd1;
                // A completion arriving on the deadline cycle still counts as on time.
                if (rsp_valid) begin
                    buf_wr_en   = 1'b1;
                    buf_wr_addr = job;
                    if (job == JW'(NJOBS - 1)) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_ISSUE;
                        job_nxt   = job + 1'b1;
                    end
                end else if (tmo_cnt == 16'(TIMEOUT - 1)) begin
                    state_nxt = S_ERR;
                end
            end
            S_DONE, S_ERR: begin
                done        = (state == S_DONE);
                err_timeout = (state == S_ERR);
                if (start) begin
                    state_nxt   = S_ISSUE;
                    job_nxt     = '0;
                    tmo_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Abort must not leave a handshake or buffer write half-done in its own cycle.
        if (abort) begin
            state_nxt    = S_IDLE;
            job_nxt      = '0;
            tmo_cnt_nxt  = '0;
            req_valid    = 1'b0;
            req_is_noise = 1'b0;
            req_x        = '0;
            req_y        = '0;
            buf_wr_en    = 1'b0;
            buf_wr_addr  = '0;
        end
    end

    assign job_idx = job;

endmodule

// File: tb/tb_kyber_sample_scheduler.sv
// Directed bench for kyber_sample_scheduler: full runs, ready stalls, deadline edge,
// timeout, abort and async reset, with a short TIMEOUT to keep runs small.
module tb_kyber_sample_scheduler;

    localparam int TMO = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       req_ready = 1'b0;
    logic       rsp_valid = 1'b0;
    logic       req_valid;
    logic       req_is_noise;
    logic [7:0] req_x;
    logic [7:0] req_y;
    logic       buf_wr_en;
    logic [3:0] buf_wr_addr;
    logic       busy;
    logic       done;
    logic       err_timeout;
    logic [3:0] job_idx;

    int total = 0;
    int bad = 0;

`ifdef KYBER_MATRIX_TRANSPOSE_EN
    int exp_x [16] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 0, 1, 2, 3, 4, 5, 6};
    int exp_y [16] = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0};
`else
    int exp_x [16] = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 1, 2, 3, 4, 5, 6};
    int exp_y [16] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 0, 0, 0, 0, 0, 0, 0};
`endif

    kyber_sample_scheduler #(.K(3), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_noise (req_is_noise),
        .req_x        (req_x),
        .req_y        (req_y),
        .rsp_valid    (rsp_valid),
        .buf_wr_en    (buf_wr_en),
        .buf_wr_addr  (buf_wr_addr),
        .busy         (busy),
        .done         (done),
        .err_timeout  (err_timeout),
        .job_idx      (job_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered just after a falling edge while the DUT is in ISSUE for job j.
    task automatic issue_accept(input int j, input int rdly);
        chk("req_valid", 32'(req_valid), 1);
        chk("req_is_noise", 32'(req_is_noise), (j >= 9) ? 1 : 0);
        chk("req_x", 32'(req_x), exp_x[j]);
        chk("req_y", 32'(req_y), exp_y[j]);
        chk("job_idx", 32'(job_idx), j);
        for (int c = 0; c < rdly; c++) begin
            @(negedge clk); #1;
            chk("stall_valid", 32'(req_valid), 1);
            chk("stall_x", 32'(req_x), exp_x[j]);
            chk("stall_y", 32'(req_y), exp_y[j]);
            chk("stall_no_wr", 32'(buf_wr_en), 0);
            chk("stall_no_err", 32'(err_timeout), 0);
        end
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        #1;
        chk("wait_valid_low", 32'(req_valid), 0);
        chk("wait_busy", 32'(busy), 1);
    endtask

    // Completion lands on WAIT cycle rdly-1 (counter value rdly-1).
    task automatic respond(input int j, input int rdly);
        repeat (rdly - 1) @(negedge clk);
        rsp_valid = 1'b1;
        #1;
        chk("wr_en", 32'(buf_wr_en), 1);
        chk("wr_addr", 32'(buf_wr_addr), j);
        @(negedge clk);
        rsp_valid = 1'b0;
        #1;
        chk("next_req_bubble", 32'(req_valid), (j < 15) ? 1 : 0);
        chk("done_flag", 32'(done), (j == 15) ? 1 : 0);
        chk("no_err", 32'(err_timeout), 0);
    endtask

    task automatic run_jobs(input int first, input int last, input int slow_job,
                            input int slow_rdy, input int slow_rsp, input int base_rsp);
        for (int j = first; j <= last; j++) begin
            if (j == slow_job) begin
                issue_accept(j, slow_rdy);
                respond(j, slow_rsp);
            end else begin
                issue_accept(j, 0);
                respond(j, base_rsp);
            end
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("start_busy", 32'(busy), 1);
        chk("start_done_clr", 32'(done), 0);
        chk("start_err_clr", 32'(err_timeout), 0);
        chk("start_job0", 32'(job_idx), 0);
    endtask

    initial begin
        // reset values
        #3;
        chk("rst_req_valid", 32'(req_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err_timeout), 0);
        chk("rst_job", 32'(job_idx), 0);
        chk("rst_wr_en", 32'(buf_wr_en), 0);
        @(negedge clk);
        rst = 1'b0;

        // stray completion while idle
        @(negedge clk);
        rsp_valid = 1'b1;
        #1;
        chk("idle_rsp_no_wr", 32'(buf_wr_en), 0);
        @(negedge clk);
        rsp_valid = 1'b0;

        // full run, 30-cycle sampler
        do_start();
        run_jobs(0, 15, -1, 0, 0, 30);
        chk("run1_idle_busy", 32'(busy), 0);

        // restart from DONE; job 4 stalled on ready, answered on the deadline cycle
        do_start();
        run_jobs(0, 15, 4, 10, TMO, 3);

        // timeout on job 5
        do_start();
        run_jobs(0, 4, -1, 0, 0, 3);
        issue_accept(5, 0);
        repeat (TMO - 1) @(negedge clk);
        #1;
        chk("pre_tmo_err", 32'(err_timeout), 0);
        chk("pre_tmo_busy", 32'(busy), 1);
        @(negedge clk); #1;
        chk("tmo_err", 32'(err_timeout), 1);
        chk("tmo_busy", 32'(busy), 0);
        chk("tmo_req_valid", 32'(req_valid), 0);
        repeat (5) @(negedge clk);
        rsp_valid = 1'b1;
        #1;
        chk("err_rsp_no_wr", 32'(buf_wr_en), 0);
        chk("err_held", 32'(err_timeout), 1);
        chk("err_no_req", 32'(req_valid), 0);
        @(negedge clk);
        rsp_valid = 1'b0;
        do_start();
        chk("restart_x", 32'(req_x), 0);
        chk("restart_valid", 32'(req_valid), 1);

        // start ignored while busy, then abort during WAIT of job 7
        run_jobs(0, 6, -1, 0, 0, 3);
        issue_accept(7, 0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("busy_start_job", 32'(job_idx), 7);
        chk("busy_start_wait", 32'(req_valid), 0);
        @(negedge clk);
        abort = 1'b1;
        rsp_valid = 1'b1;
        #1;
        chk("abort_no_wr", 32'(buf_wr_en), 0);
        chk("abort_no_req", 32'(req_valid), 0);
        @(negedge clk);
        abort = 1'b0;
        rsp_valid = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_req_valid", 32'(req_valid), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_err", 32'(err_timeout), 0);
        repeat (3) @(negedge clk);
        rsp_valid = 1'b1;
        #1;
        chk("late_rsp_no_wr", 32'(buf_wr_en), 0);
        @(negedge clk);
        rsp_valid = 1'b0;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        #1;
        chk("start_abort_busy", 32'(busy), 0);
        chk("start_abort_valid", 32'(req_valid), 0);
        @(negedge clk); #1;
        chk("start_abort_stay", 32'(busy), 0);

        // async reset in WAIT of job 3, then clean full run
        do_start();
        run_jobs(0, 2, -1, 0, 0, 3);
        issue_accept(3, 0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_job", 32'(job_idx), 0);
        chk("arst_valid", 32'(req_valid), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_err", 32'(err_timeout), 0);
        @(negedge clk);
        rst = 1'b0;
        do_start();
        run_jobs(0, 15, -1, 0, 0, 5);
        chk("final_busy", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
